// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, aligned byte/half/word access to a
// word-addressed RAM with one-cycle registered read latency.
module load_store_unit #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [2:0]          i_req_funct3,
  input  logic [31:0]         i_req_addr,
  input  logic [31:0]         i_req_wdata,
  output logic                o_resp_valid,
  output logic [31:0]         o_resp_rdata,
  output logic                o_resp_err,
  output logic                o_read_enable,
  output logic [ADDR_WIDTH:0] o_read_addr,
  input  logic [DATA_WIDTH:0] i_read_data,
  output logic                o_write_enable,
  output logic [3:0]          o_byte_enable,
  output logic [ADDR_WIDTH:0] o_write_addr,
  output logic [DATA_WIDTH:0] o_write_data
);

  localparam int AW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state_reg;
  logic          we_reg;
  logic [2:0]    funct3_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   wdata_reg;
  logic [31:0]   rdata_reg;
  logic          err_reg;

  logic          req_illegal;
  logic          req_misaligned;
  logic          req_error;
  logic          issue;
  logic [AW-1:0] ram_addr;
  logic [3:0]    store_be;
  logic [DATA_WIDTH:0] store_data;
  logic [31:0]   shifted;
  logic [31:0]   load_ext;

  // Request legality is judged on the live inputs so the error path skips the RAM entirely.
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    case (i_req_funct3)
      3'b000, 3'b100: req_misaligned = 1'b0;
      3'b001, 3'b101: req_misaligned = i_req_addr[0];
      3'b010:         req_misaligned = |i_req_addr[1:0];
      default:        req_illegal    = 1'b1;
    endcase
    if (i_req_we && i_req_funct3[2]) begin
      req_illegal = 1'b1;
    end
  end

  assign req_error = req_illegal | req_misaligned;

  assign ram_addr = AW'(addr_reg[31:2]);

  always_comb begin
    store_be   = 4'b1111;
    store_data = wdata_reg;
    case (funct3_reg[1:0])
      2'b00: begin
        store_be   = 4'b0001 << addr_reg[1:0];
        store_data = {4{wdata_reg[7:0]}};
      end
      2'b01: begin
        store_be   = 4'b0011 << addr_reg[1:0];
        store_data = {2{wdata_reg[15:0]}};
      end
      default: begin
        store_be   = 4'b1111;
        store_data = wdata_reg;
      end
    endcase
  end

  assign shifted = 32'(i_read_data) >> {addr_reg[1:0], 3'b000};

  always_comb begin
    case (funct3_reg)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // RAM port is quiet outside ISSUE so nothing leaks onto the bus between accesses.
  assign issue          = (state_reg == ISSUE);
  assign o_read_enable  = issue & ~we_reg;
  assign o_write_enable = issue & we_reg;
  assign o_read_addr    = o_read_enable  ? ram_addr   : '0;
  assign o_write_addr   = o_write_enable ? ram_addr   : '0;
  assign o_byte_enable  = o_write_enable ? store_be   : 4'b0000;
  assign o_write_data   = o_write_enable ? store_data : '0;

  assign o_req_ready  = (state_reg == IDLE);
  assign o_resp_valid = (state_reg == RESP);
  assign o_resp_rdata = rdata_reg;
  assign o_resp_err   = err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      we_reg     <= 1'b0;
      funct3_reg <= 3'b000;
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
      rdata_reg  <= 32'd0;
      err_reg    <= 1'b0;
    end else if (clk_en) begin
      case (state_reg)
        IDLE: begin
          if (i_req_valid) begin
            we_reg     <= i_req_we;
            funct3_reg <= i_req_funct3;
            addr_reg   <= i_req_addr;
            wdata_reg  <= i_req_wdata;
            rdata_reg  <= 32'd0;
            err_reg    <= req_error;
            state_reg  <= req_error ? RESP : ISSUE;
          end
        end
        ISSUE: state_reg <= we_reg ? RESP : WAIT;
        WAIT: begin
          rdata_reg <= load_ext;
          state_reg <= RESP;
        end
        RESP: begin
          rdata_reg <= 32'd0;
          err_reg   <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized traffic
// compared against a byte-level memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;
  logic        o_read_enable;
  logic [31:0] o_read_addr;
  logic [31:0] ram_rdata;
  logic        o_write_enable;
  logic [3:0]  o_byte_enable;
  logic [31:0] o_write_addr;
  logic [31:0] o_write_data;

  int checks   = 0;
  int failures = 0;

  load_store_unit dut (
    .clk            (clk),
    .rst            (rst),
    .clk_en         (clk_en),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_we       (i_req_we),
    .i_req_funct3   (i_req_funct3),
    .i_req_addr     (i_req_addr),
    .i_req_wdata    (i_req_wdata),
    .o_resp_valid   (o_resp_valid),
    .o_resp_rdata   (o_resp_rdata),
    .o_resp_err     (o_resp_err),
    .o_read_enable  (o_read_enable),
    .o_read_addr    (o_read_addr),
    .i_read_data    (ram_rdata),
    .o_write_enable (o_write_enable),
    .o_byte_enable  (o_byte_enable),
    .o_write_addr   (o_write_addr),
    .o_write_data   (o_write_data)
  );

  always #5 clk = ~clk;

  // RAM: 64 words, registered read, byte-enabled write, seeded on its first clock
  logic [31:0] mem [0:63];
  logic [31:0] ram_w;
  bit          ram_ready = 1'b0;

  function automatic logic [31:0] seed_word(input int i);
    return (32'h9E3779B9 * 32'(i + 1)) ^ 32'(i << 7);
  endfunction

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= seed_word(i);
      ram_ready <= 1'b1;
    end else begin
      if (o_read_enable) ram_rdata <= mem[o_read_addr[5:0]];
      if (o_write_enable) begin
        ram_w = mem[o_write_addr[5:0]];
        for (int b = 0; b < 4; b++)
          if (o_byte_enable[b]) ram_w[8*b +: 8] = o_write_data[8*b +: 8];
        mem[o_write_addr[5:0]] <= ram_w;
      end
    end
  end

  // Reference model: flat byte-addressed memory
  logic [7:0] shadow [0:255];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int size;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (we && f3 >= 3'd4) return 1'b1;
    size = 1 << f3[1:0];
    return (int'(a[7:0]) % size) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int a);
    int size;
    longint v;
    size = 1 << f3[1:0];
    v = 0;
    for (int k = 0; k < size; k++) v = v | (longint'(shadow[a + k]) << (8 * k));
    if (!f3[2] && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8 * size));
    return v[31:0];
  endfunction

  task automatic do_reset_pulse();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One transaction; called and returns at a negedge with the block idle.
  task automatic do_txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit toggle, input bit junk);
    bit          err, got, saw_rd, saw_wr, en_now;
    int          exp_lat, n, size, lane;
    logic [31:0] exp_rd, rd_addr, wr_addr, wr_data, exp_wd;
    logic [3:0]  be, exp_be;

    err     = model_err(we, f3, a);
    exp_lat = err ? 1 : (we ? 2 : 3);
    check("ready_before", 32'(o_req_ready), 32'd1);
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_funct3 = f3;
    i_req_addr   = a;
    i_req_wdata  = wd;
    clk_en       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_req_valid = junk;
    if (junk) begin
      i_req_we     = 1'($urandom_range(0, 1));
      i_req_funct3 = 3'($urandom_range(0, 7));
      i_req_addr   = $urandom_range(0, 255);
      i_req_wdata  = $urandom;
    end
    n = 1; got = 1'b0; saw_rd = 1'b0; saw_wr = 1'b0;
    be = 4'd0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    for (int c = 0; c < 40 && !got; c++) begin
      check("rw_exclusive", 32'(o_read_enable & o_write_enable), 32'd0);
      if (o_write_enable) begin
        saw_wr = 1'b1; be = o_byte_enable; wr_addr = o_write_addr; wr_data = o_write_data;
      end
      if (o_read_enable) begin
        saw_rd = 1'b1; rd_addr = o_read_addr;
      end
      if (o_resp_valid) begin
        got = 1'b1;
      end else begin
        clk_en = toggle ? ~clk_en : 1'b1;
        en_now = clk_en;
        @(posedge clk);
        if (en_now) n++;
        @(negedge clk);
      end
    end
    i_req_valid = 1'b0;
    check("resp_seen", 32'(got), 32'd1);
    if (!got) begin
      do_reset_pulse();
      return;
    end
    exp_rd = (err || we) ? 32'd0 : model_load(f3, int'(a[7:0]));
    check("latency", n, exp_lat);
    check("resp_err", 32'(o_resp_err), 32'(err));
    check("resp_rdata", o_resp_rdata, exp_rd);
    check("read_issued", 32'(saw_rd), 32'(!err && !we));
    check("write_issued", 32'(saw_wr), 32'(!err && we));
    if (saw_rd) check("read_addr", rd_addr, a >> 2);
    if (saw_wr) begin
      size = 1 << f3[1:0];
      lane = int'(a[1:0]);
      exp_be = 4'd0;
      for (int k = 0; k < size; k++) exp_be[lane + k] = 1'b1;
      for (int b = 0; b < 4; b++) exp_wd[8*b +: 8] = wd[8*(b % size) +: 8];
      check("write_addr", wr_addr, a >> 2);
      check("byte_enable", 32'(be), 32'(exp_be));
      check("write_data", wr_data, exp_wd);
      for (int k = 0; k < size; k++) shadow[int'(a[7:0]) + k] = wd[8*k +: 8];
    end
    $display("txn we=%0d f3=%0d addr=0x%02h wdata=0x%08h rdata=0x%08h err=%0d lat=%0d toggle=%0d",
             we, f3, a[7:0], wd, o_resp_rdata, o_resp_err, n, toggle);
    clk_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("hold_valid", 32'(o_resp_valid), 32'd1);
    check("hold_rdata", o_resp_rdata, exp_rd);
    check("hold_err", 32'(o_resp_err), 32'(err));
    clk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("clr_valid", 32'(o_resp_valid), 32'd0);
    check("clr_rdata", o_resp_rdata, 32'd0);
    check("clr_err", 32'(o_resp_err), 32'd0);
  endtask

  task automatic check_outputs_idle(input string tag);
    check({tag, "_ready"}, 32'(o_req_ready), 32'd1);
    check({tag, "_valid"}, 32'(o_resp_valid), 32'd0);
    check({tag, "_rdata"}, o_resp_rdata, 32'd0);
    check({tag, "_err"}, 32'(o_resp_err), 32'd0);
    check({tag, "_ram_en"}, 32'({o_read_enable, o_write_enable}), 32'd0);
    check({tag, "_ram_bus"}, o_read_addr | o_write_addr | o_write_data | 32'(o_byte_enable), 32'd0);
  endtask

  initial begin
    logic [31:0] w, saved;
    logic [2:0]  legal_f3 [0:4];
    logic [2:0]  f3;
    logic [31:0] a;
    bit          we;
    int          size;

    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
    legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
    for (int i = 0; i < 64; i++) begin
      w = seed_word(i);
      for (int b = 0; b < 4; b++) shadow[4*i + b] = w[8*b +: 8];
    end

    rst = 1'b0; clk_en = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0;
    i_req_funct3 = 3'd0; i_req_addr = 32'd0; i_req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check_outputs_idle("reset");
    rst = 1'b1;

    // Directed scenarios
    do_txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
    do_txn(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b0);
    check("lw_deadbeef", model_load(3'd2, 32'h10), 32'hDEADBEEF);
    do_txn(1'b1, 3'd0, 32'h13, 32'h80, 1'b0, 1'b0);
    do_txn(1'b0, 3'd0, 32'h13, 32'h0, 1'b0, 1'b0);
    do_txn(1'b0, 3'd4, 32'h13, 32'h0, 1'b0, 1'b0);
    do_txn(1'b1, 3'd1, 32'h22, 32'h1234, 1'b0, 1'b0);
    do_txn(1'b0, 3'd1, 32'h22, 32'h0, 1'b0, 1'b0);
    do_txn(1'b0, 3'd2, 32'h11, 32'h0, 1'b0, 1'b0);
    do_txn(1'b0, 3'd3, 32'h20, 32'h0, 1'b0, 1'b0);
    do_txn(1'b1, 3'd4, 32'h24, 32'h55, 1'b0, 1'b0);

    // Store aborted by reset during ISSUE
    saved = mem[16];
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_funct3 = 3'd2;
    i_req_addr = 32'h40; i_req_wdata = 32'hCAFEF00D; clk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    check("abort_in_issue", 32'(o_write_enable), 32'd1);
    rst = 1'b0;
    #1;
    check_outputs_idle("abort");
    @(posedge clk);
    @(negedge clk);
    check("abort_no_write", mem[16], saved);
    rst = 1'b1;
    do_txn(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 1'b0);

    // Load with clk_en toggling every cycle
    do_txn(1'b1, 3'd2, 32'h30, 32'hA5C3_1E7F, 1'b0, 1'b0);
    do_txn(1'b0, 3'd2, 32'h30, 32'h0, 1'b1, 1'b0);
    do_txn(1'b0, 3'd0, 32'h31, 32'h0, 1'b1, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) != 0) f3 = legal_f3[$urandom_range(0, we ? 2 : 4)];
      else f3 = 3'($urandom_range(0, 7));
      a = $urandom_range(0, 255);
      size = 1 << f3[1:0];
      if ($urandom_range(0, 3) != 0) a = a & ~32'(size - 1);
      do_txn(we, f3, a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=0x%08h exp=0x%08h", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
